// File: rtl/sb_drain_arbiter.sv
// Store-buffer drain arbiter: shares the dcache port between cached stores and loads,
// and sequences uncached stores over the bus. Optional perf counters under SB_DRAIN_PERF_EN.
module sb_drain_arbiter #(
  parameter  int SB_SIZE    = 4,
  parameter  int HI_WM      = 3,
  parameter  int STARVE_MAX = 7,
  localparam int CNT_W      = $clog2(SB_SIZE) + 1,
  localparam int SV_W       = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sb_valid_i,
  output logic             sb_ready_o,
  input  logic [31:0]      sb_addr_i,
  input  logic [31:0]      sb_data_i,
  input  logic [3:0]       sb_strb_i,
  input  logic             sb_uc_i,
  input  logic [CNT_W-1:0] sb_cnt_i,
  input  logic             drain_req_i,
  input  logic             ld_valid_i,
  input  logic [31:0]      ld_addr_i,
  output logic             ld_ready_o,
  output logic             dc_valid_o,
  output logic             dc_we_o,
  output logic [31:0]      dc_addr_o,
  output logic [31:0]      dc_wdata_o,
  output logic [3:0]       dc_wstrb_o,
  input  logic             dc_ready_i,
  output logic             uc_valid_o,
  output logic [31:0]      uc_addr_o,
  output logic [31:0]      uc_data_o,
  output logic [3:0]       uc_strb_o,
  input  logic             uc_ready_i,
  input  logic             uc_bvalid_i,
  output logic             sb_empty_o
`ifdef SB_DRAIN_PERF_EN
  ,
  output logic [31:0]      perf_st_cnt_o,
  output logic [31:0]      perf_uc_cnt_o,
  output logic [31:0]      perf_starve_cnt_o
`endif
);

  // state     | meaning
  // S_IDLE    | cached stores / loads arbitrate; uncached head starts a bus write
  // S_UC_REQ  | uc_valid_o held with captured payload until uc_ready_i
  // S_UC_WAIT | waiting for bus write response
  // S_UC_POP  | pop the uncached head for one cycle
  typedef enum logic [1:0] {S_IDLE, S_UC_REQ, S_UC_WAIT, S_UC_POP} state_t;

  state_t          state, state_nxt;
  logic [SV_W-1:0] starve_cnt, starve_nxt;
  logic            uc_valid_nxt, uc_capture;
  logic            st_cand, st_prio, st_gnt, ld_gnt, starve_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      uc_valid_o <= 1'b0;
      uc_addr_o  <= '0;
      uc_data_o  <= '0;
      uc_strb_o  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      uc_valid_o <= uc_valid_nxt;
      if (uc_capture) begin
        uc_addr_o <= sb_addr_i;
        uc_data_o <= sb_data_i;
        uc_strb_o <= sb_strb_i;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    uc_valid_nxt = uc_valid_o;
    uc_capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (sb_valid_i && sb_uc_i) begin
          state_nxt    = S_UC_REQ;
          uc_valid_nxt = 1'b1;
          uc_capture   = 1'b1;
        end
      end
      S_UC_REQ: begin
        if (uc_ready_i) begin
          state_nxt    = S_UC_WAIT;
          uc_valid_nxt = 1'b0;
        end
      end
      S_UC_WAIT: if (uc_bvalid_i) state_nxt = S_UC_POP;
      S_UC_POP:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Dcache arbitration is purely combinational and re-evaluated every cycle.
  always_comb begin
    starve_max = (starve_cnt == SV_W'(STARVE_MAX));
    st_cand    = (state == S_IDLE) && sb_valid_i && !sb_uc_i;
    st_prio    = (sb_cnt_i >= CNT_W'(HI_WM)) || drain_req_i || starve_max;
    st_gnt     = st_cand && (st_prio || !ld_valid_i);
    ld_gnt     = !st_gnt && ld_valid_i;

    dc_valid_o = st_gnt || ld_gnt;
    dc_we_o    = st_gnt;
    dc_addr_o  = '0;
    dc_wdata_o = '0;
    dc_wstrb_o = '0;
    if (st_gnt) begin
      dc_addr_o  = sb_addr_i;
      dc_wdata_o = sb_data_i;
      dc_wstrb_o = sb_strb_i;
    end else if (ld_gnt) begin
      dc_addr_o  = ld_addr_i;
    end

    sb_ready_o = (st_gnt && dc_ready_i) || (state == S_UC_POP);
    ld_ready_o = ld_gnt && dc_ready_i;
    sb_empty_o = (sb_cnt_i == '0) && (state == S_IDLE);

    starve_nxt = starve_cnt;
    if (st_gnt && dc_ready_i)
      starve_nxt = '0;
    else if (st_cand && ld_gnt && !starve_max)
      starve_nxt = starve_cnt + SV_W'(1);
  end

`ifdef SB_DRAIN_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_st_cnt_o     <= '0;
      perf_uc_cnt_o     <= '0;
      perf_starve_cnt_o <= '0;
    end else begin
      if (sb_valid_i && sb_ready_o) perf_st_cnt_o     <= perf_st_cnt_o + 32'd1;
      if (state == S_UC_POP)        perf_uc_cnt_o     <= perf_uc_cnt_o + 32'd1;
      if (starve_max)               perf_starve_cnt_o <= perf_starve_cnt_o + 32'd1;
    end
  end
`endif

endmodule
